// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA definitions for the instruction fetch unit: opcodes, field extractors, FSM states.
// Optional predecode outputs are enabled with IFETCH_PREDECODE_EN.
package instr_fetch_unit_pkg;

  localparam int PC_W_DEF = 8;
  localparam int IW_DEF   = 32;

  localparam logic [4:0] OP_MOV  = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd11;
  localparam logic [4:0] OP_HALT = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALTED = 3'd4
  } ifu_state_e;

  function automatic logic [4:0] f_oper_type(input logic [31:0] ir);
    return ir[31:27];
  endfunction

  function automatic logic [4:0] f_rdst(input logic [31:0] ir);
    return ir[26:22];
  endfunction

  function automatic logic [4:0] f_rsrc1(input logic [31:0] ir);
    return ir[21:17];
  endfunction

  function automatic logic f_imm_mode(input logic [31:0] ir);
    return ir[16];
  endfunction

  function automatic logic [4:0] f_rsrc2(input logic [31:0] ir);
    return ir[15:11];
  endfunction

  function automatic logic [15:0] f_isrc(input logic [31:0] ir);
    return ir[15:0];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: imem read port plus the ir valid/ready handshake toward the core.
// Predecode fields appear only when IFETCH_PREDECODE_EN is defined.
interface instr_fetch_unit_if #(
  parameter int PC_W = 8,
  parameter int IW   = 32
);
  logic            imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [IW-1:0]   imem_rdata;
  logic [IW-1:0]   ir_out;
  logic            ir_valid;
  logic            ir_ready;
  logic [PC_W-1:0] pc_out;
`ifdef IFETCH_PREDECODE_EN
  logic [4:0]      oper_type;
  logic [4:0]      rdst;
  logic [4:0]      rsrc1;
  logic            imm_mode;
  logic [4:0]      rsrc2;
  logic [15:0]     isrc;
`endif

  modport master (
    input  imem_rdata, ir_ready,
    output imem_en, imem_addr, ir_out, ir_valid, pc_out
`ifdef IFETCH_PREDECODE_EN
    , output oper_type, rdst, rsrc1, imm_mode, rsrc2, isrc
`endif
  );

  modport slave (
    output imem_rdata, ir_ready,
    input  imem_en, imem_addr, ir_out, ir_valid, pc_out
`ifdef IFETCH_PREDECODE_EN
    , input oper_type, rdst, rsrc1, imm_mode, rsrc2, isrc
`endif
  );
endinterface

// File: rtl/instr_fetch_unit_ir_field_split.sv
// Predecode register: splits the fetched word into ISA fields, loaded together with ir_out.
// Only built when IFETCH_PREDECODE_EN is defined.
`ifdef IFETCH_PREDECODE_EN
module ir_field_split
  import instr_fetch_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] ir_i,
  output logic [4:0]  oper_type_o,
  output logic [4:0]  rdst_o,
  output logic [4:0]  rsrc1_o,
  output logic        imm_mode_o,
  output logic [4:0]  rsrc2_o,
  output logic [15:0] isrc_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oper_type_o <= '0;
      rdst_o      <= '0;
      rsrc1_o     <= '0;
      imm_mode_o  <= 1'b0;
      rsrc2_o     <= '0;
      isrc_o      <= '0;
    end else if (load_i) begin
      oper_type_o <= f_oper_type(ir_i);
      rdst_o      <= f_rdst(ir_i);
      rsrc1_o     <= f_rsrc1(ir_i);
      imm_mode_o  <= f_imm_mode(ir_i);
      rsrc2_o     <= f_rsrc2(ir_i);
      isrc_o      <= f_isrc(ir_i);
    end
  end

endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: reads synchronous imem at pc and hands words to the core.
// IFETCH_PREDECODE_EN adds registered ISA field outputs on the bus interface.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// REQ     | imem_en high, imem_addr = pc
// WAIT    | imem_rdata valid; captured into ir_out, pc advances
// ISSUE   | ir_valid high until the core takes the word
// HALTED  | HALT consumed, waiting for start
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int         PC_W    = PC_W_DEF,
  parameter int         IW      = IW_DEF,
  parameter logic [4:0] HALT_OP = OP_HALT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [PC_W-1:0] pc_init_i,
  input  logic            branch_en_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic            halted_o,
  instr_fetch_unit_if.master bus
);

  ifu_state_e      state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_out_q;
  logic [IW-1:0]   ir_q;
  logic            imem_en_q;
  logic            ir_valid_q;
  logic            halted_q;
  logic [PC_W-1:0] pc_inc_d;
  logic            is_halt_d;

  assign pc_inc_d  = pc_q + PC_W'(1);
  assign is_halt_d = (f_oper_type(ir_q[31:0]) == HALT_OP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      pc_out_q   <= '0;
      ir_q       <= '0;
      imem_en_q  <= 1'b0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (start_i) begin
            state_q   <= S_REQ;
            pc_q      <= pc_init_i;
            imem_en_q <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        S_REQ: begin
          // a redirect here just re-issues the read at the new address
          if (branch_en_i) begin
            pc_q      <= branch_target_i;
            imem_en_q <= 1'b1;
          end else begin
            state_q   <= S_WAIT;
            imem_en_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (branch_en_i) begin
            state_q   <= S_REQ;
            pc_q      <= branch_target_i;
            imem_en_q <= 1'b1;
          end else begin
            state_q    <= S_ISSUE;
            ir_q       <= bus.imem_rdata;
            pc_out_q   <= pc_q;
            pc_q       <= pc_inc_d;
            ir_valid_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          // branch beats both a pending handshake and a HALT word
          if (branch_en_i) begin
            state_q    <= S_REQ;
            pc_q       <= branch_target_i;
            imem_en_q  <= 1'b1;
            ir_valid_q <= 1'b0;
          end else if (bus.ir_ready) begin
            ir_valid_q <= 1'b0;
            if (is_halt_d) begin
              state_q  <= S_HALTED;
              halted_q <= 1'b1;
            end else begin
              state_q   <= S_REQ;
              imem_en_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          imem_en_q  <= 1'b0;
          ir_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_en   = imem_en_q;
  assign bus.imem_addr = pc_q;
  assign bus.ir_out    = ir_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.pc_out    = pc_out_q;
  assign halted_o      = halted_q;

`ifdef IFETCH_PREDECODE_EN
  logic pd_load;
  assign pd_load = (state_q == S_WAIT) && !branch_en_i;

  ir_field_split u_ir_field_split (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (pd_load),
    .ir_i        (bus.imem_rdata[31:0]),
    .oper_type_o (bus.oper_type),
    .rdst_o      (bus.rdst),
    .rsrc1_o     (bus.rsrc1),
    .imm_mode_o  (bus.imm_mode),
    .rsrc2_o     (bus.rsrc2),
    .isrc_o      (bus.isrc)
  );
`endif

endmodule
